ofifo: RTL
==========

Name: ofifo

Overview:
- Output FIFO at the south edge of the MAC array inside the corelet.
- The L0/IFIFO buffer data into the array; this block does the reverse: it captures per-column psums from out_s, qualified by the per-column valid strobes.
- Each column has its own queue, because columns fire skewed in time.
- A downstream reader (SFP/PSUM SRAM writeback) pops one full row, one word from every column, per read.

Parameters:
- col, 8, number of array columns / independent column queues
- psum_bw, 16, bits per psum word
- depth, 64, entries per column queue (power of 2, >= 2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in  input  psum_bw*col  psum words; column c at bits [psum_bw*(c+1)-1 : psum_bw*c]
- wr  input  col  per-column write strobe (driven by mac_array valid)
- rd  input  1  pop one word from every column
- out  output  psum_bw*col  registered row of popped words, same column packing as in
- o_full  output  1  at least one column queue is full
- o_ready  output  1  no column queue is full (~o_full)
- o_valid  output  1  every column queue is non-empty; a row is available
- o_overflow  output  1  sticky: a write hit a full column

Behaviour:
- Reset (reset==0, asynchronous):
  - all read/write pointers = 0
  - out = 0, o_overflow = 0
  - o_full = 0, o_ready = 1, o_valid = 0
  - storage contents need no reset
- Pointers:
  - ptr width = log2(depth)+1; the extra MSB gives the wrap bit
  - empty: wptr == rptr
  - full: low bits equal and MSBs differ
  - pointers wrap naturally modulo 2*depth
- Write, per column c, independent of the other columns:
  - if wr[c] && !full_c at the clock edge, mem_c[wptr_c] <= in word c and wptr_c increments
  - if wr[c] && full_c, the word is dropped, wptr_c is unchanged and o_overflow sets to 1 (stays 1 until reset)
- Read:
  - rd is honoured only when o_valid==1 at the clock edge
  - on an honoured read, every column outputs mem_c[rptr_c] on out in the next cycle (1-cycle latency), and all rptr_c increment together
  - rd with o_valid==0 is ignored: pointers unchanged, out holds its previous value
- out holds the last popped row until the next honoured rd.
- Simultaneous read and write on the same column:
  - full is evaluated on pre-edge state, so a write to a full column is dropped even when the same edge pops it (no write-through)
  - on a non-full column, both the read and the write happen and the occupancy is unchanged
  - on an empty column, o_valid==0, so the read is ignored; the write proceeds and the column becomes non-empty next cycle
- Flags are combinational from the registered pointers and reflect the state after the last edge:
  - o_full = OR of full_c over all columns
  - o_ready = ~o_full
  - o_valid = AND of ~empty_c over all columns
- Occupancy per column is 0..depth.
- Reset asserted mid-operation: pointers clear immediately; buffered data is discarded.

Decomposition:
- Shared corelet package holds the constants:
  - COL=8, PSUM_BW=16, OFIFO_DEPTH=64
  - OFIFO_PTR_W = $clog2(OFIFO_DEPTH)+1
- One natural sub-module: ofifo_col_fifo, a single-column queue.
  - ports: clk, reset, wr, rd, in, out_word, o_full, o_empty
  - ofifo instantiates col copies with a generate loop
  - rd to each copy is gated by the top-level o_valid
  - o_overflow, the flag reduction and the out register live at the top level

Test Plan:
- Reset, then idle -> out=0, o_valid=0, o_ready=1, o_full=0, o_overflow=0.
- Write all 8 columns in the same cycle with column c = 16'h0100+c, then rd=1 one cycle later -> o_valid=1 after the write edge; out = {16'h0107,...,16'h0100} one cycle after rd; o_valid returns to 0.
- Skewed writes: column c written at cycle t+c with value c -> o_valid stays 0 until column 7 is written, then rises the next cycle; rd issued earlier is ignored with pointers unmoved.
- Fill column 3 with 64 writes (other columns empty) -> o_full=1, o_ready=0; 65th write (value 16'hDEAD) is dropped and o_overflow=1. After filling the others and draining 64 rows, column 3 returns values 0..63 and never 16'hDEAD.
- Wrap-around: 200 writes/reads interleaved at one per cycle on every column, with incrementing data -> the popped sequence is exactly in order, no flags are asserted, and the pointers wrap past 64.
- Reset asserted mid-stream with 10 rows buffered -> o_valid drops asynchronously and out=0. After release, o_valid=0 and o_overflow=0 until new writes arrive.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared corelet constants for the array south-edge output FIFO.
package ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

  typedef logic [PSUM_BW-1:0] psum_t;

endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column psum queue: write when not full, read when not empty; out_word shows the head combinationally.
// Latency: a word is visible at the head the cycle after its write; writes to a full queue are dropped.
module ofifo_col_fifo
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] in,
  output logic [psum_bw-1:0] out_word,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [psum_bw-1:0] mem [depth];
  logic               do_wr;
  logic               do_rd;

  // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign do_wr = wr && !o_full;
  assign do_rd = rd && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PW'(1);
      if (do_rd) rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= in;
  end

  assign out_word = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ofifo.sv
// Output FIFO at the array south edge: one queue per column, popped a full row at a time.
// Latency: popped row appears on out one cycle after an honoured rd; rd is ignored until every column holds a word.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic                   o_overflow
);

  logic [col-1:0]         full_v;
  logic [col-1:0]         empty_v;
  logic [psum_bw*col-1:0] head_row;
  logic                   pop;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col_fifo #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr[c]),
      .rd       (pop),
      .in       (in[psum_bw*c +: psum_bw]),
      .out_word (head_row[psum_bw*c +: psum_bw]),
      .o_full   (full_v[c]),
      .o_empty  (empty_v[c])
    );
  end

  assign o_full  = |full_v;
  assign o_ready = ~o_full;
  assign o_valid = &(~empty_v);
  // Columns only pop together, so a row is never split across reads.
  assign pop     = rd && o_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop) out <= head_row;
      if (|(wr & full_v)) o_overflow <= 1'b1;
    end
  end

endmodule
